// File: rtl/sequenciador_mux_pkg.sv
// ---------------------------------------------------------------------------
// sequenciador_mux_pkg
// Shared definitions for the two-channel output sequencer and its bench:
//   - estado_t      : FSM state encoding (OCIOSO / APRESENTA_A / APRESENTA_B)
//   - LARGURA_PADRAO: default data word width of both channels and the mux
// ---------------------------------------------------------------------------
package sequenciador_mux_pkg;

    localparam int LARGURA_PADRAO = 32;

    typedef enum logic [1:0] {
        OCIOSO      = 2'd0,
        APRESENTA_A = 2'd1,
        APRESENTA_B = 2'd2
    } estado_t;

endpackage

// File: rtl/registro_canal.sv
// ---------------------------------------------------------------------------
// registro_canal
// One-word holding register with full flag and ready/valid input handshake.
// Ports:
//   Clock, Reset   : system clock, asynchronous active-high reset
//   dado, valido   : incoming word and its valid strobe
//   drenar         : the sequencer is consuming this register on this edge
//   pronto         : register can accept a word this cycle
//   registro       : held word (drives the mux input directly)
//   cheioProximo   : full flag as it will be after this edge (load/drain applied)
// ---------------------------------------------------------------------------
module registro_canal
    import sequenciador_mux_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [LARGURA-1:0] dado,
    input  logic               valido,
    input  logic               drenar,
    output logic               pronto,
    output logic [LARGURA-1:0] registro,
    output logic               cheioProximo
);

    logic cheio;
    logic carga;

    // A draining register may be refilled on the same edge, so a full
    // register still reports ready while it is being consumed.
    assign pronto       = ~Reset & (~cheio | drenar);
    assign carga        = valido & pronto;
    assign cheioProximo = carga | (cheio & ~drenar);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            registro <= '0;
            cheio    <= 1'b0;
        end else begin
            if (carga) begin
                registro <= dado;
            end
            cheio <= cheioProximo;
        end
    end

endmodule

// File: rtl/sequenciador_mux.sv
// ---------------------------------------------------------------------------
// sequenciador_mux
// Collects words from two ready/valid channels (A, B) into holding registers
// and sequences them onto an external 2:1 mux, round-robin when both wait.
// Ports:
//   Clock, Reset              : system clock, asynchronous active-high reset
//   dadoA/validoA/prontoA     : channel A input handshake
//   dadoB/validoB/prontoB     : channel B input handshake
//   entradaA, entradaB        : holding registers, wired to the mux inputs
//   controle                  : mux select (0 = A, 1 = B)
//   saida_valida/saida_pronto : output handshake of the mux word
//   contador                  : completed output transfers, wraps 255 -> 0
// ---------------------------------------------------------------------------
module sequenciador_mux
    import sequenciador_mux_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [LARGURA-1:0] dadoA,
    input  logic               validoA,
    output logic               prontoA,
    input  logic [LARGURA-1:0] dadoB,
    input  logic               validoB,
    output logic               prontoB,
    output logic [LARGURA-1:0] entradaA,
    output logic [LARGURA-1:0] entradaB,
    output logic               controle,
    output logic               saida_valida,
    input  logic               saida_pronto,
    output logic [7:0]         contador
);

    estado_t estadoReg;
    estado_t estadoNext;
    logic    ultimoFoiB;      // last completed transfer came from channel B
    logic    ultimoFoiBNext;
    logic    transferencia;
    logic    drenarA;
    logic    drenarB;
    logic    cheioProxA;
    logic    cheioProxB;

    assign transferencia = saida_valida & saida_pronto;
    assign drenarA       = transferencia & (estadoReg == APRESENTA_A);
    assign drenarB       = transferencia & (estadoReg == APRESENTA_B);

    registro_canal #(.LARGURA(LARGURA)) canalA (
        .Clock        (Clock),
        .Reset        (Reset),
        .dado         (dadoA),
        .valido       (validoA),
        .drenar       (drenarA),
        .pronto       (prontoA),
        .registro     (entradaA),
        .cheioProximo (cheioProxA)
    );

    registro_canal #(.LARGURA(LARGURA)) canalB (
        .Clock        (Clock),
        .Reset        (Reset),
        .dado         (dadoB),
        .valido       (validoB),
        .drenar       (drenarB),
        .pronto       (prontoB),
        .registro     (entradaB),
        .cheioProximo (cheioProxB)
    );

    // Next state is decided from the full flags as they stand after this
    // edge's loads and drains; while a word waits on backpressure nothing moves.
    always_comb begin
        estadoNext     = estadoReg;
        ultimoFoiBNext = ultimoFoiB;
        if (transferencia) begin
            ultimoFoiBNext = (estadoReg == APRESENTA_B);
        end
        if ((estadoReg == OCIOSO) || transferencia) begin
            case ({cheioProxA, cheioProxB})
                2'b10:   estadoNext = APRESENTA_A;
                2'b01:   estadoNext = APRESENTA_B;
                2'b11:   estadoNext = ultimoFoiBNext ? APRESENTA_A : APRESENTA_B;
                default: estadoNext = OCIOSO;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with estadoReg.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            estadoReg    <= OCIOSO;
            ultimoFoiB   <= 1'b1;
            saida_valida <= 1'b0;
            controle     <= 1'b0;
            contador     <= 8'd0;
        end else begin
            estadoReg    <= estadoNext;
            ultimoFoiB   <= ultimoFoiBNext;
            saida_valida <= (estadoNext != OCIOSO);
            controle     <= (estadoNext == APRESENTA_B);
            if (transferencia) begin
                contador <= contador + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_sequenciador_mux.sv
// ---------------------------------------------------------------------------
// tb_sequenciador_mux
// Directed, self-checking bench for sequenciador_mux. Inputs change 1 time
// unit after a rising edge; outputs are checked at that same point, i.e.
// well away from the active edge.
// ---------------------------------------------------------------------------
module tb_sequenciador_mux;
    import sequenciador_mux_pkg::*;

    localparam int W = LARGURA_PADRAO;

    logic         Clock;
    logic         Reset;
    logic [W-1:0] dadoA;
    logic         validoA;
    logic         prontoA;
    logic [W-1:0] dadoB;
    logic         validoB;
    logic         prontoB;
    logic [W-1:0] entradaA;
    logic [W-1:0] entradaB;
    logic         controle;
    logic         saida_valida;
    logic         saida_pronto;
    logic [7:0]   contador;

    int erros = 0;
    int checks = 0;

    sequenciador_mux #(.LARGURA(W)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .dadoA        (dadoA),
        .validoA      (validoA),
        .prontoA      (prontoA),
        .dadoB        (dadoB),
        .validoB      (validoB),
        .prontoB      (prontoB),
        .entradaA     (entradaA),
        .entradaB     (entradaB),
        .controle     (controle),
        .saida_valida (saida_valida),
        .saida_pronto (saida_pronto),
        .contador     (contador)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic ciclo();
        @(posedge Clock);
        #1;
    endtask

    task automatic verifica(input string tag, input logic [W-1:0] obs, input logic [W-1:0] esp);
        checks++;
        assert (obs === esp) else begin
            erros++;
            $error("FAIL %s: observado=%h esperado=%h", tag, obs, esp);
        end
    endtask

    task automatic pulsoReset();
        #2 Reset = 1'b1;
        #1 Reset = 1'b0;
    endtask

    initial begin
        Reset        = 1'b1;
        dadoA        = '0;
        dadoB        = '0;
        validoA      = 1'b0;
        validoB      = 1'b0;
        saida_pronto = 1'b0;

        // Reset state
        #2;
        verifica("rst_valida",   W'(saida_valida), W'(1'b0));
        verifica("rst_controle", W'(controle),     W'(1'b0));
        verifica("rst_contador", W'(contador),     W'(0));
        verifica("rst_prontoA",  W'(prontoA),      W'(1'b0));
        verifica("rst_prontoB",  W'(prontoB),      W'(1'b0));
        verifica("rst_entradaA", entradaA,         W'(0));
        #10 Reset = 1'b0;
        ciclo();

        // Single word on A
        verifica("a_prontoA", W'(prontoA), W'(1'b1));
        dadoA = 32'h8000_0001; validoA = 1'b1; saida_pronto = 1'b1;
        ciclo();
        validoA = 1'b0;
        verifica("a_valida",   W'(saida_valida), W'(1'b1));
        verifica("a_controle", W'(controle),     W'(1'b0));
        verifica("a_entradaA", entradaA,         32'h8000_0001);
        ciclo();
        verifica("a_fim_valida",   W'(saida_valida), W'(1'b0));
        verifica("a_fim_contador", W'(contador),     W'(1));
        $display("txn single_A contador=%0d", contador);

        // Round-robin after reset: both loaded together -> A then B
        pulsoReset();
        verifica("rr_rst_contador", W'(contador), W'(0));
        ciclo();
        dadoA = 32'h1111_1111; dadoB = 32'h2222_2222;
        validoA = 1'b1; validoB = 1'b1; saida_pronto = 1'b1;
        ciclo();
        validoA = 1'b0; validoB = 1'b0;
        verifica("rr1_controle", W'(controle), W'(1'b0));
        verifica("rr1_entradaA", entradaA,     32'h1111_1111);
        ciclo();
        verifica("rr2_valida",   W'(saida_valida), W'(1'b1));
        verifica("rr2_controle", W'(controle),     W'(1'b1));
        verifica("rr2_entradaB", entradaB,         32'h2222_2222);
        verifica("rr2_contador", W'(contador),     W'(1));
        ciclo();
        verifica("rr_fim_valida",   W'(saida_valida), W'(1'b0));
        verifica("rr_fim_contador", W'(contador),     W'(2));
        $display("txn round_robin contador=%0d", contador);

        // Backpressure on B: offered words must be refused
        dadoB = 32'hBBBB_0001; validoB = 1'b1; saida_pronto = 1'b0;
        ciclo();
        dadoB = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            verifica("bp_controle", W'(controle), W'(1'b1));
            verifica("bp_entradaB", entradaB,     32'hBBBB_0001);
            verifica("bp_prontoB",  W'(prontoB),  W'(1'b0));
            verifica("bp_contador", W'(contador), W'(2));
            ciclo();
        end
        validoB = 1'b0; saida_pronto = 1'b1;
        ciclo();
        verifica("bp_fim_contador", W'(contador),     W'(3));
        verifica("bp_fim_valida",   W'(saida_valida), W'(1'b0));
        $display("txn backpressure contador=%0d", contador);

        // Same-cycle drain and refill of A
        dadoA = 32'hA0A0_A0A0; validoA = 1'b1; saida_pronto = 1'b0;
        ciclo();
        dadoA = 32'h3333_3333; saida_pronto = 1'b1;
        #1;
        verifica("dr_prontoA", W'(prontoA), W'(1'b1));
        ciclo();
        validoA = 1'b0;
        verifica("dr_entradaA", entradaA,         32'h3333_3333);
        verifica("dr_valida",   W'(saida_valida), W'(1'b1));
        verifica("dr_controle", W'(controle),     W'(1'b0));
        verifica("dr_contador", W'(contador),     W'(4));
        ciclo();
        verifica("dr_fim_contador", W'(contador), W'(5));
        $display("txn drain_refill contador=%0d", contador);

        // Round-robin with last served = A: B goes first
        dadoA = 32'h4444_4444; dadoB = 32'h5555_5555;
        validoA = 1'b1; validoB = 1'b1;
        ciclo();
        validoA = 1'b0; validoB = 1'b0;
        verifica("rrb1_controle", W'(controle), W'(1'b1));
        verifica("rrb1_entradaB", entradaB,     32'h5555_5555);
        ciclo();
        verifica("rrb2_controle", W'(controle), W'(1'b0));
        verifica("rrb2_entradaA", entradaA,     32'h4444_4444);
        verifica("rrb2_contador", W'(contador), W'(6));
        ciclo();
        verifica("rrb_fim_contador", W'(contador), W'(7));
        $display("txn round_robin_B_first contador=%0d", contador);

        // Wrap: 256 back-to-back transfers from A
        pulsoReset();
        ciclo();
        validoA = 1'b1; saida_pronto = 1'b1;
        for (int i = 0; i < 256; i++) begin
            dadoA = W'(i);
            ciclo();
        end
        validoA = 1'b0;
        verifica("wr_contador255", W'(contador), W'(255));
        verifica("wr_entradaA",    entradaA,     W'(255));
        ciclo();
        verifica("wr_contador0", W'(contador),     W'(0));
        verifica("wr_valida",    W'(saida_valida), W'(1'b0));
        $display("txn wrap contador=%0d", contador);

        // Asynchronous reset with both registers full
        dadoA = 32'h6666_6666; dadoB = 32'h7777_7777;
        validoA = 1'b1; validoB = 1'b1;
        ciclo();
        validoA = 1'b0; validoB = 1'b0;
        ciclo();
        saida_pronto = 1'b0;
        dadoB = 32'h8888_8888; validoB = 1'b1;
        ciclo();
        validoB = 1'b0;
        verifica("ar_pre_contador", W'(contador),     W'(1));
        verifica("ar_pre_valida",   W'(saida_valida), W'(1'b1));
        #3 Reset = 1'b1;
        #1;
        verifica("ar_valida",   W'(saida_valida), W'(1'b0));
        verifica("ar_contador", W'(contador),     W'(0));
        verifica("ar_controle", W'(controle),     W'(1'b0));
        verifica("ar_prontoA",  W'(prontoA),      W'(1'b0));
        verifica("ar_entradaB", entradaB,         W'(0));
        #1 Reset = 1'b0;
        ciclo();
        verifica("ar_pos_valida", W'(saida_valida), W'(1'b0));
        $display("txn async_reset contador=%0d", contador);

        $display("Result: errors=%0d of %0d checks", erros, checks);
        $finish;
    end

endmodule

// File: doc/sequenciador_mux.md
SEQUENCIADOR_MUX -- requirements
Module: sequenciador_mux

Interface
REQ-001 SHALL have parameter LARGURA, default 32, data word width of both operand channels and mux outputs.
REQ-002 SHALL have port Clock  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port dadoA  input  LARGURA  operand word, channel A.
REQ-005 SHALL have port validoA  input  1  dadoA valid.
REQ-006 SHALL have port prontoA  output  1  channel A can accept a word this cycle.
REQ-007 SHALL have ports dadoB, validoB, prontoB, with the same widths and meanings as the channel A ports, for channel B.
REQ-008 SHALL have port entradaA  output  LARGURA  channel A holding register, feeds Mux2_1.entradaA.
REQ-009 SHALL have port entradaB  output  LARGURA  channel B holding register, feeds Mux2_1.entradaB.
REQ-010 SHALL have port controle  output  1  mux select; 0 = present A, 1 = present B.
REQ-011 SHALL have port saida_valida  output  1  the mux output (saida) carries a valid word.
REQ-012 SHALL have port saida_pronto  input  1  the downstream stage accepts saida this cycle.
REQ-013 SHALL have port contador  output  8  count of completed output transfers.

Function
REQ-014 SHALL hold one word per channel (regA, regB), each with a full flag.
REQ-015 SHALL drive entradaA and entradaB directly from regA and regB at all times.
REQ-016 SHALL assert prontoX when regX is empty, or when regX is being drained this cycle (same-cycle drain and refill are allowed).
REQ-017 SHALL load regX and set its full flag on a rising edge where validoX and prontoX are both 1.
REQ-018 SHALL use an FSM with three states: OCIOSO (saida_valida=0, controle=0), APRESENTA_A (saida_valida=1, controle=0) and APRESENTA_B (saida_valida=1, controle=1).
REQ-019 SHALL complete an output transfer on an edge where saida_valida and saida_pronto are both 1; that edge clears the full flag of the presented register and increments contador.
REQ-020 SHALL hold state, controle and the presented register unchanged while saida_valida=1 and saida_pronto=0.
REQ-021 SHALL compute the next state, when in OCIOSO or on a transfer edge, from the full flags after that edge's loads and clears, as follows:
- only A full -> APRESENTA_A;
- only B full -> APRESENTA_B;
- both full -> the channel not served by the last transfer (round-robin);
- neither full -> OCIOSO.
REQ-022 SHALL have 1-cycle latency: a word loaded at edge t into an idle block is presented (saida_valida=1) from edge t onward, i.e. visible in cycle t+1.
REQ-023 SHALL, when both channels are loaded on the same edge while in OCIOSO with last-served=B, present A first.
REQ-024 SHALL wrap contador from 255 to 0 with no flag.
REQ-025 SHALL allow back-to-back transfers: one transfer per cycle while words are available and saida_pronto=1.

Reset
REQ-026 SHALL, while Reset=1 and regardless of Clock, force: state OCIOSO, both full flags 0, regA=regB=0, contador=0, last-served=B, saida_valida=0, controle=0.
REQ-027 SHALL, on assertion of Reset mid-transfer, discard all held words; no transfer completes on an edge where Reset=1.
REQ-028 SHALL drive prontoA=prontoB=0 while Reset=1.

Structure
REQ-029 SHALL place the state encoding (OCIOSO=2'd0, APRESENTA_A=2'd1, APRESENTA_B=2'd2) and the LARGURA default in a shared package/include file used by the block and its bench.
REQ-030 SHALL be built as one top module instantiating one sub-module, registro_canal (holding register, full flag, prontoX logic), twice; the FSM and contador SHALL sit in the top module.

Verification
REQ-031 SHALL cover single A: A=0x80000001 with validoA=1 for 1 cycle and saida_pronto=1 -> next cycle saida_valida=1, controle=0, entradaA=0x80000001; the cycle after -> saida_valida=0, contador=1.
REQ-032 SHALL cover round-robin: A=0x11111111 and B=0x22222222 loaded on the same edge after reset -> A presented first, then B; contador=2.
REQ-033 SHALL cover backpressure: saida_pronto=0 for 5 cycles with B held -> controle=1 and entradaB constant throughout, prontoB=0, contador unchanged.
REQ-034 SHALL cover same-cycle drain and refill: A presented with saida_pronto=1 while validoA=1 with 0x33333333 -> prontoA=1, next cycle entradaA=0x33333333 and saida_valida=1.
REQ-035 SHALL cover wrap: 256 transfers -> contador returns to 0.
REQ-036 SHALL cover reset mid-operation: Reset asserted asynchronously with both registers full -> saida_valida=0 and contador=0 immediately, with no clock edge needed.
